// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Producer side of the pipeline forwarding path. Keeps a shadow pipeline of
// destination tags (destination register, cycles-until-ready, result source)
// for the E, M and W stages. Compares those tags against the source registers
// held in D, E and M to produce every Forward_Sel code for the bypass muxes,
// plus the D-stage stall.
//
// Ports
//   clk        in  1  clock, all state on rising edge
//   rst_n      in  1  asynchronous, active-low reset
//   rs_D       in  5  D-stage rs index
//   rt_D       in  5  D-stage rt index
//   use_rs_D   in  1  D instruction reads rs
//   use_rt_D   in  1  D instruction reads rt
//   tuse_rs_D  in  2  cycles until rs is consumed (0=D, 1=E, 2=M)
//   tuse_rt_D  in  2  cycles until rt is consumed
//   a3_D       in  5  D instruction destination register (0 = none)
//   tnew_D     in  2  cycles after entering E until the result exists
//   src_D      in  2  result source: 0=ALU, 1=LINK (PC+8), 2=MEM
//   stall      out 1  hold PC/IF-ID, insert a bubble into E
//   fsel_rs_D  out 3  Forward_Sel, D-stage rs mux (branch compare)
//   fsel_rt_D  out 3  Forward_Sel, D-stage rt mux
//   fsel_rs_E  out 3  Forward_Sel, E-stage ALU A mux
//   fsel_rt_E  out 3  Forward_Sel, E-stage ALU B / store-data mux
//   fsel_rt_M  out 3  Forward_Sel, M-stage store-data mux (mf_wd or mf_rd)
//
// Forward_Sel codes: 0=mf_rd, 1=mf_pc4e, 2=mf_ao, 3=mf_pc4m, 4=mf_wd.
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic       use_rs_D,
    input  logic       use_rt_D,
    input  logic [1:0] tuse_rs_D,
    input  logic [1:0] tuse_rt_D,
    input  logic [4:0] a3_D,
    input  logic [1:0] tnew_D,
    input  logic [1:0] src_D,
    output logic       stall,
    output logic [2:0] fsel_rs_D,
    output logic [2:0] fsel_rt_D,
    output logic [2:0] fsel_rs_E,
    output logic [2:0] fsel_rt_E,
    output logic [2:0] fsel_rt_M
);

    localparam logic [2:0] MF_RD   = 3'd0;
    localparam logic [2:0] MF_PC4E = 3'd1;
    localparam logic [2:0] MF_AO   = 3'd2;
    localparam logic [2:0] MF_PC4M = 3'd3;
    localparam logic [2:0] MF_WD   = 3'd4;

    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_LINK = 2'd1;

    // Shadow tag pipeline
    logic       vld_e, vld_m, vld_w;
    logic [4:0] a3_e, a3_m, a3_w;
    logic [1:0] tnew_e, tnew_m, tnew_w;
    logic [1:0] src_e, src_m;
    logic [4:0] rs_e, rt_e, rt_m;
    // The W-stage source is not tracked: the W mux input is already the
    // final writeback value, whatever produced it.

    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // A tag matches only when valid, non-zero and equal; $0 never matches.
    function automatic logic hit(input logic v, input logic [4:0] a,
                                 input logic [4:0] r);
        return v && (a != 5'd0) && (a == r);
    endfunction

    // Youngest matching producer decides. A young match that is not ready
    // yet blocks older ones and leaves the select at mf_rd.
    function automatic logic [2:0] sel_for(input logic [4:0] r,
                                           input logic search_e,
                                           input logic search_m);
        logic [2:0] s;
        s = MF_RD;
        if (search_e && hit(vld_e, a3_e, r)) begin
            if (tnew_e == 2'd0 && src_e == SRC_LINK) s = MF_PC4E;
        end else if (search_m && hit(vld_m, a3_m, r)) begin
            if (tnew_m == 2'd0) begin
                if (src_m == SRC_ALU)       s = MF_AO;
                else if (src_m == SRC_LINK) s = MF_PC4M;
            end
        end else if (hit(vld_w, a3_w, r) && tnew_w == 2'd0) begin
            s = MF_WD;
        end
        return s;
    endfunction

    // Hazard when the youngest matching producer will not have its value
    // by the time the consumer needs it. W is always ready.
    function automatic logic hz(input logic [4:0] r, input logic [1:0] t);
        logic h;
        h = 1'b0;
        if (hit(vld_e, a3_e, r))      h = (tnew_e > t);
        else if (hit(vld_m, a3_m, r)) h = (tnew_m > t);
        return h;
    endfunction

    assign stall = (use_rs_D && hz(rs_D, tuse_rs_D)) ||
                   (use_rt_D && hz(rt_D, tuse_rt_D));

    assign fsel_rs_D = sel_for(rs_D, 1'b1, 1'b1);
    assign fsel_rt_D = sel_for(rt_D, 1'b1, 1'b1);
    assign fsel_rs_E = sel_for(rs_e, 1'b0, 1'b1);
    assign fsel_rt_E = sel_for(rt_e, 1'b0, 1'b1);
    assign fsel_rt_M = sel_for(rt_m, 1'b0, 1'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_e  <= 1'b0;
            a3_e   <= 5'd0;
            tnew_e <= 2'd0;
            src_e  <= 2'd0;
            rs_e   <= 5'd0;
            rt_e   <= 5'd0;
            vld_m  <= 1'b0;
            a3_m   <= 5'd0;
            tnew_m <= 2'd0;
            src_m  <= 2'd0;
            rt_m   <= 5'd0;
            vld_w  <= 1'b0;
            a3_w   <= 5'd0;
            tnew_w <= 2'd0;
        end else begin
            if (stall) begin
                // D holds; E receives a bubble that can never match.
                vld_e  <= 1'b0;
                a3_e   <= 5'd0;
                tnew_e <= 2'd0;
                src_e  <= 2'd0;
                rs_e   <= 5'd0;
                rt_e   <= 5'd0;
            end else begin
                vld_e  <= 1'b1;
                a3_e   <= a3_D;
                tnew_e <= tnew_D;
                src_e  <= src_D;
                rs_e   <= rs_D;
                rt_e   <= rt_D;
            end
            // M and W always advance.
            vld_m  <= vld_e;
            a3_m   <= a3_e;
            tnew_m <= dec_sat(tnew_e);
            src_m  <= src_e;
            rt_m   <= rt_e;
            vld_w  <= vld_m;
            a3_w   <= a3_m;
            tnew_w <= dec_sat(tnew_m);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [1:0] src;
        logic       e_stall;
        logic [2:0] e_rs_d;
        logic [2:0] e_rt_d;
        logic [2:0] e_rs_e;
        logic [2:0] e_rt_e;
        logic [2:0] e_rt_m;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs_D, rt_D, a3_D;
    logic       use_rs_D, use_rt_D;
    logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D, src_D;
    logic       stall;
    logic [2:0] fsel_rs_D, fsel_rt_D, fsel_rs_E, fsel_rt_E, fsel_rt_M;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vec_q[$];

    fwd_hazard_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_D      (rs_D),
        .rt_D      (rt_D),
        .use_rs_D  (use_rs_D),
        .use_rt_D  (use_rt_D),
        .tuse_rs_D (tuse_rs_D),
        .tuse_rt_D (tuse_rt_D),
        .a3_D      (a3_D),
        .tnew_D    (tnew_D),
        .src_D     (src_D),
        .stall     (stall),
        .fsel_rs_D (fsel_rs_D),
        .fsel_rt_D (fsel_rt_D),
        .fsel_rs_E (fsel_rs_E),
        .fsel_rt_E (fsel_rt_E),
        .fsel_rt_M (fsel_rt_M)
    );

    // Clock: rising edges at 5, 15, ...; inputs change and are checked
    // around the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt,
                       input logic [1:0] trs, input logic [1:0] trt,
                       input logic [4:0] a3, input logic [1:0] tn,
                       input logic [1:0] sr, input logic st,
                       input logic [2:0] f0, input logic [2:0] f1,
                       input logic [2:0] f2, input logic [2:0] f3,
                       input logic [2:0] f4);
        vec_t v;
        v.rs = rs; v.rt = rt; v.use_rs = urs; v.use_rt = urt;
        v.tuse_rs = trs; v.tuse_rt = trt; v.a3 = a3; v.tnew = tn; v.src = sr;
        v.e_stall = st; v.e_rs_d = f0; v.e_rt_d = f1; v.e_rs_e = f2;
        v.e_rt_e = f3; v.e_rt_m = f4;
        vec_q.push_back(v);
    endtask

    task automatic idle(input logic [2:0] f2, input logic [2:0] f3,
                        input logic [2:0] f4);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, f2, f3, f4);
    endtask

    task automatic drive(input vec_t v);
        rs_D = v.rs; rt_D = v.rt; use_rs_D = v.use_rs; use_rt_D = v.use_rt;
        tuse_rs_D = v.tuse_rs; tuse_rt_D = v.tuse_rt;
        a3_D = v.a3; tnew_D = v.tnew; src_D = v.src;
    endtask

    task automatic check(input string name, input logic [2:0] got,
                         input logic [2:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic st,
                             input logic [2:0] f0, input logic [2:0] f1,
                             input logic [2:0] f2, input logic [2:0] f3,
                             input logic [2:0] f4);
        check({tag, " stall"},     {2'b00, stall}, {2'b00, st});
        check({tag, " fsel_rs_D"}, fsel_rs_D, f0);
        check({tag, " fsel_rt_D"}, fsel_rt_D, f1);
        check({tag, " fsel_rs_E"}, fsel_rs_E, f2);
        check({tag, " fsel_rt_E"}, fsel_rt_E, f3);
        check({tag, " fsel_rt_M"}, fsel_rt_M, f4);
    endtask

    initial begin
        vec_t z;
        z = '{default: '0};

        // Expected values below are sampled before the rising edge that
        // captures the row's D inputs.
        // idle after reset
        idle(0, 0, 0);
        // addu $3 -> subu reading $3 in E
        add(1, 2, 1, 1, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        add(3, 4, 1, 1, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 0, 0);
        idle(0, 0, 0); idle(0, 0, 0); idle(0, 0, 0);
        // lw $5 -> beq $5 (tuse 0): two stall cycles, then mf_wd
        add(29, 0, 1, 0, 1, 0, 5, 2, 2, 0, 0, 0, 0, 0, 0);
        add(5, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(5, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0);
        idle(0, 0, 0); idle(0, 0, 0); idle(0, 0, 0);
        // jal -> jr $31 -> next reader of $31
        add(0, 0, 0, 0, 0, 0, 31, 0, 1, 0, 0, 0, 0, 0, 0);
        add(31, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(31, 0, 1, 0, 1, 0, 0, 0, 0, 0, 3, 0, 3, 0, 0);
        idle(4, 0, 0);
        idle(0, 0, 0); idle(0, 0, 0);
        // lw $6 -> sw $6 (tuse 2): no stall, store data from W in M
        add(29, 0, 1, 0, 1, 0, 6, 2, 2, 0, 0, 0, 0, 0, 0);
        add(29, 6, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0);
        idle(0, 0, 4);
        idle(0, 0, 0); idle(0, 0, 0);
        // write $0 with tnew 2, then reader of $0
        add(0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0);
        // addu $8 then link to $8: E wins over M, then M wins over W
        add(0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 8, 0, 1, 0, 0, 0, 0, 0, 0);
        add(8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(3, 0, 0);
        idle(0, 0, 0); idle(0, 0, 0);
        // addu $9 then lw $9: the E load decides the stall, blocks M
        add(0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        add(29, 0, 1, 0, 1, 0, 9, 2, 2, 0, 0, 0, 0, 0, 0);
        add(9, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(9, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4, 0, 0);
        idle(0, 0, 0); idle(0, 0, 0);

        // Reset phase
        drive(z);
        rst_n = 1'b0;
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_all("reset_held", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Table-driven rows
        foreach (vec_q[i]) begin
            drive(vec_q[i]);
            #1;
            check_all($sformatf("row%0d", i), vec_q[i].e_stall,
                      vec_q[i].e_rs_d, vec_q[i].e_rt_d, vec_q[i].e_rs_e,
                      vec_q[i].e_rt_e, vec_q[i].e_rt_m);
            @(negedge clk);
        end

        // Reset asserted in the middle of a load-use stall
        begin
            vec_t lw_v, beq_v;
            lw_v = z;  lw_v.rs = 29; lw_v.use_rs = 1; lw_v.tuse_rs = 1;
            lw_v.a3 = 10; lw_v.tnew = 2; lw_v.src = 2;
            beq_v = z; beq_v.rs = 10; beq_v.use_rs = 1; beq_v.tuse_rs = 0;
            drive(lw_v);
            @(negedge clk);
            drive(beq_v);
            #1;
            check({"rst_mid stall_before"}, {2'b00, stall}, 3'd1);
            #1;
            rst_n = 1'b0;
            #1;
            check_all("rst_mid async", 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            check_all("rst_mid released", 0, 0, 0, 0, 0, 0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
